// File: rtl/ram_port_arb_pkg.sv
// Shared constants for the training-engine RAM port arbiter.
// Holds the FSM state encoding, requester index constants and default address width,
// plus the fixed-priority / round-robin owner selection helper.
package ram_port_arb_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 12;

   // Requester indices into the packed request / owner vectors
   localparam int LOAD = 0;
   localparam int SGD  = 1;
   localparam int DUMP = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_OWN_LOAD = 3'd1,
      ST_OWN_SGD  = 3'd2,
      ST_OWN_DUMP = 3'd3,
      ST_TURN     = 3'd4
   } state_t;

   // Load always wins; SGD and dump alternate on a tie. last_dump set means
   // dump was the most recent read owner, so SGD is next in line.
   function automatic state_t pick_owner(input logic [2:0] reqs, input logic last_dump);
      state_t s;
      if (reqs[LOAD])                    s = ST_OWN_LOAD;
      else if (reqs[SGD] && reqs[DUMP])  s = last_dump ? ST_OWN_SGD : ST_OWN_DUMP;
      else if (reqs[SGD])                s = ST_OWN_SGD;
      else if (reqs[DUMP])               s = ST_OWN_DUMP;
      else                               s = ST_IDLE;
      return s;
   endfunction

endpackage

// File: rtl/ram_port_arb.sv
// Arbiter/sequencer sharing the single-port training RAM between loader (write), SGD and dump (reads).
// Ports: CLK/RST (async active-low); req_*/addr_* per requester; registered one-hot gnt_*;
// ram_addr/ram_we/ram_oe combinational from grants and reqs; busy while owned or turning around.
import ram_port_arb_pkg::*;

module ram_port_arb #(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int MAX_BURST  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req_load,
   input  logic [ADDR_WIDTH-1:0] addr_load,
   input  logic                  req_sgd,
   input  logic [ADDR_WIDTH-1:0] addr_sgd,
   input  logic                  req_dump,
   input  logic [ADDR_WIDTH-1:0] addr_dump,
   output logic                  gnt_load,
   output logic                  gnt_sgd,
   output logic                  gnt_dump,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic                  busy
);

   localparam logic [7:0] MAX_B = MAX_BURST[7:0];
   localparam logic [7:0] LIMIT = MAX_B - 8'd1;

   state_t     state, nxt_state, tgt;
   logic [7:0] burst_cnt;
   logic       last_dump;
   logic [2:0] reqs, owner;
   logic       access, others, at_limit;

   assign reqs     = {req_dump, req_sgd, req_load};
   assign owner    = {state == ST_OWN_DUMP, state == ST_OWN_SGD, state == ST_OWN_LOAD};
   assign access   = |(owner & reqs);
   assign others   = |(~owner & reqs);
   // Reaching (or already sitting at) the burst cap makes this access the last
   // one if anybody else is waiting; a lone owner just saturates and keeps going.
   assign at_limit = burst_cnt >= LIMIT;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ST_IDLE;
      else      state <= nxt_state;
   end

   // Next-state logic
   always_comb begin
      nxt_state = state;
      tgt       = ST_IDLE;
      case (state)
         ST_IDLE, ST_TURN: begin
            // TURN re-arbitrates against live requests rather than a latched target
            nxt_state = pick_owner(reqs, last_dump);
         end
         ST_OWN_LOAD, ST_OWN_SGD, ST_OWN_DUMP: begin
            if (!access || (at_limit && others)) begin
               // The outgoing owner is masked so a forced release actually hands over
               tgt = pick_owner(reqs & ~owner, last_dump);
               if (tgt == ST_IDLE)
                  nxt_state = ST_IDLE;
               else if ((tgt == ST_OWN_LOAD) != (state == ST_OWN_LOAD))
                  nxt_state = ST_TURN;   // write<->read needs a dead bus cycle
               else
                  nxt_state = tgt;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // Burst counter and round-robin pointer
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         burst_cnt <= 8'd0;
         last_dump <= 1'b1;
      end else if (nxt_state != state &&
                   (nxt_state == ST_OWN_LOAD || nxt_state == ST_OWN_SGD || nxt_state == ST_OWN_DUMP)) begin
         burst_cnt <= 8'd0;
         if (nxt_state == ST_OWN_SGD)  last_dump <= 1'b0;
         if (nxt_state == ST_OWN_DUMP) last_dump <= 1'b1;
      end else if (access && burst_cnt != MAX_B) begin
         burst_cnt <= burst_cnt + 8'd1;
      end
   end

   // Output decode
   always_comb begin
      gnt_load = owner[LOAD];
      gnt_sgd  = owner[SGD];
      gnt_dump = owner[DUMP];
      ram_we   = gnt_load & req_load;
      ram_oe   = (gnt_sgd & req_sgd) | (gnt_dump & req_dump);
      busy     = (state != ST_IDLE);
      ram_addr = '0;
      case (state)
         ST_OWN_LOAD: ram_addr = addr_load;
         ST_OWN_SGD:  ram_addr = addr_sgd;
         ST_OWN_DUMP: ram_addr = addr_dump;
         default:     ram_addr = '0;
      endcase
   end

endmodule

// File: tb/tb_ram_port_arb.sv
// Scoreboarded bench for ram_port_arb with MAX_BURST=4: directed requester patterns,
// expected RAM accesses queued by the stimulus and popped by a negedge monitor,
// plus direct grant/busy checks at the turnaround, release and reset points.
import ram_port_arb_pkg::*;

module tb_ram_port_arb;

   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          req_load = 1'b0, req_sgd = 1'b0, req_dump = 1'b0;
   logic [AW-1:0] addr_load = '0, addr_sgd = '0, addr_dump = '0;
   logic          gnt_load, gnt_sgd, gnt_dump, ram_we, ram_oe, busy;
   logic [AW-1:0] ram_addr;

   int total = 0;
   int bad   = 0;
   logic [16:0] exp_q[$];

   ram_port_arb #(.ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
      .CLK(CLK), .RST(RST),
      .req_load(req_load), .addr_load(addr_load),
      .req_sgd(req_sgd),   .addr_sgd(addr_sgd),
      .req_dump(req_dump), .addr_dump(addr_dump),
      .gnt_load(gnt_load), .gnt_sgd(gnt_sgd), .gnt_dump(gnt_dump),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Access record: {we, oe, gnt_dump, gnt_sgd, gnt_load, addr}
   function automatic logic [16:0] acc(int who, int a);
      logic [2:0] g;
      logic [11:0] ad;
      g  = 3'(1 << who);
      ad = 12'(a);
      return {who == LOAD, who != LOAD, g, ad};
   endfunction

   task automatic chk(string name, int act, int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle the RAM is actually accessed must match the next expected record
   always @(negedge CLK) begin
      if (RST === 1'b1 && (ram_we || ram_oe)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_access: got %0h expected none at %0t",
                     {ram_we, ram_oe, gnt_dump, gnt_sgd, gnt_load, ram_addr}, $time);
         end else begin
            chk("access", int'({ram_we, ram_oe, gnt_dump, gnt_sgd, gnt_load, ram_addr}),
                int'(exp_q.pop_front()));
         end
      end
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      RST = 1'b0;
      req_load = 0; req_sgd = 0; req_dump = 0;
      addr_load = '0; addr_sgd = '0; addr_dump = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_outputs", int'({gnt_dump, gnt_sgd, gnt_load, ram_we, ram_oe, busy, ram_addr}), 0);
      next_cycle();
      RST = 1'b1;
      @(negedge CLK);
      chk("idle_outputs", int'({gnt_dump, gnt_sgd, gnt_load, ram_we, ram_oe, busy, ram_addr}), 0);
   endtask

   initial begin
      // Reset and idle
      reset_dut();

      // Single load burst: 5 writes at addresses 0..4, grant drops one cycle after req
      for (int c = 0; c <= 7; c++) begin
         next_cycle();
         req_load  = (c <= 5);
         addr_load = (c >= 1 && c <= 5) ? AW'(c - 1) : '0;
         if (c >= 1 && c <= 5) exp_q.push_back(acc(LOAD, c - 1));
         @(negedge CLK);
         if (c == 0)           chk("load_latency", gnt_load, 0);
         if (c >= 1 && c <= 6) chk("load_gnt", gnt_load, 1);
         if (c == 6)           chk("load_we_after_release", ram_we, 0);
         if (c == 7)           chk("load_idle", int'({gnt_load, busy}), 0);
      end

      // Priority and turnaround: load first, then one TURN, then SGD
      reset_dut();
      for (int c = 0; c <= 9; c++) begin
         next_cycle();
         req_load  = (c <= 3);
         addr_load = AW'(12'h010 + c);
         req_sgd   = (c <= 7);
         addr_sgd  = AW'(12'h300 + c);
         if (c >= 1 && c <= 3) exp_q.push_back(acc(LOAD, 12'h010 + c));
         if (c == 6 || c == 7) exp_q.push_back(acc(SGD, 12'h300 + c));
         @(negedge CLK);
         if (c == 0) chk("prio_gnt_c0", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b000);
         if (c == 4) chk("prio_release_gnt", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b001);
         if (c == 5) chk("prio_turn", int'({gnt_dump, gnt_sgd, gnt_load, busy}), 4'b0001);
         if (c == 6) chk("prio_sgd_gnt", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b010);
         if (c == 8) chk("prio_sgd_release", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b010);
         if (c == 9) chk("prio_idle", busy, 0);
      end

      // Round-robin with burst limit 4: SGD x4, dump x4, SGD x4, no gaps
      reset_dut();
      for (int c = 0; c <= 14; c++) begin
         next_cycle();
         req_sgd   = (c <= 12);
         req_dump  = (c <= 12);
         addr_sgd  = AW'(12'h100 + c);
         addr_dump = AW'(12'h200 + c);
         if ((c >= 1 && c <= 4) || (c >= 9 && c <= 12)) exp_q.push_back(acc(SGD, 12'h100 + c));
         if (c >= 5 && c <= 8) exp_q.push_back(acc(DUMP, 12'h200 + c));
         @(negedge CLK);
         if (c >= 1 && c <= 12) chk("rr_busy", busy, 1);
         if (c == 13) chk("rr_handover_after_release", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b100);
         if (c == 14) chk("rr_idle", busy, 0);
      end

      // Burst saturation: lone SGD keeps the grant for 20 accesses
      reset_dut();
      for (int c = 0; c <= 22; c++) begin
         next_cycle();
         req_sgd  = (c <= 20);
         addr_sgd = AW'(12'h050 + c);
         if (c >= 1 && c <= 20) exp_q.push_back(acc(SGD, 12'h050 + c));
         @(negedge CLK);
         if (c == 21) chk("sat_gnt_release", gnt_sgd, 1);
         if (c == 22) chk("sat_idle", busy, 0);
      end

      // Async reset mid dump burst, then SGD wins the first tie
      reset_dut();
      for (int c = 0; c <= 3; c++) begin
         next_cycle();
         req_dump  = 1'b1;
         addr_dump = AW'(12'h2A0 + c);
         if (c >= 1) exp_q.push_back(acc(DUMP, 12'h2A0 + c));
         @(negedge CLK);
      end
      chk("pre_reset_gnt_dump", gnt_dump, 1);
      #2 RST = 1'b0;
      #1;
      chk("async_rst_outputs", int'({gnt_dump, ram_oe, busy, ram_addr}), 0);
      next_cycle();
      req_dump = 1'b0;
      @(negedge CLK);
      #1 RST = 1'b1;
      for (int c = 0; c <= 3; c++) begin
         next_cycle();
         req_sgd   = (c <= 1);
         req_dump  = (c <= 1);
         addr_sgd  = AW'(12'h111);
         addr_dump = AW'(12'h222);
         if (c == 1) exp_q.push_back(acc(SGD, 12'h111));
         @(negedge CLK);
         if (c == 1) chk("post_rst_tie_sgd", int'({gnt_dump, gnt_sgd, gnt_load}), 3'b010);
         if (c == 3) chk("post_rst_idle", busy, 0);
      end

      next_cycle();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arb.md
# ram_port_arb

Arbiter and sequencer for the single-port training-data RAM. It shares the RAM's address, write-enable and output-enable between three requesters: the serial loader (writes), the SGD engine (reads) and the weight/result dump path (reads). It replaces the fixed phase-based address mux in the top-level controller with per-cycle req/gnt handshakes. It has bounded bursts, so one requester cannot starve the others.

## Interface
- ADDR_WIDTH, 12, RAM address width.
- MAX_BURST, 16, accesses granted before forced release when another requester is pending; legal range 1..255.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- req_load  input  1  loader requests write access (level).
- addr_load  input  ADDR_WIDTH  loader address.
- req_sgd  input  1  SGD engine requests read access.
- addr_sgd  input  ADDR_WIDTH  SGD address.
- req_dump  input  1  dump path requests read access.
- addr_dump  input  ADDR_WIDTH  dump address.
- gnt_load, gnt_sgd, gnt_dump  output  1 each  registered grants; one-hot or all zero.
- ram_addr  output  ADDR_WIDTH  owner's address (combinational mux); 0 when no owner.
- ram_we  output  1  gnt_load & req_load.
- ram_oe  output  1  (gnt_sgd & req_sgd) | (gnt_dump & req_dump).
- busy  output  1  any grant high, or in TURN.

## Operation
- States: IDLE, OWN_LOAD, OWN_SGD, OWN_DUMP, TURN. Grants decode directly from state.
- Access rule: an access occurs in every cycle where the owner's gnt and req are both high. Requesters advance their address only in such cycles.
- Arbitration happens in IDLE, or when the current owner releases.
  - Load has fixed highest priority.
  - SGD and dump alternate round-robin. A 1-bit last_read pointer holds the last read owner; it resets to dump, so SGD wins the first tie.
- Release: the owner deasserts req. The grant drops at the next edge.
- Burst limit: burst_cnt (8 bits) counts accesses of the current owner.
  - On the access that makes burst_cnt == MAX_BURST, the grant drops at the next edge if any other req is high.
  - Otherwise the count saturates and the owner keeps the grant.
  - burst_cnt clears on every new grant.
- Turnaround: every change of owner between write (load) and read (sgd/dump) passes through one TURN cycle with all grants low. Read-to-read switches go directly.
- From TURN, arbitration is re-evaluated with the current reqs. The target is not latched.
- If the owner's req drops and no one else is requesting, the FSM goes to IDLE.
- Reset mid-operation clears all grants, burst_cnt and last_read immediately, since reset is asynchronous. ram_we and ram_oe fall combinationally.
- Reset values: state IDLE, all gnt 0, ram_we 0, ram_oe 0, ram_addr 0, busy 0, last_read = dump.

## Timing
- Grant latency: req rises in cycle N with the FSM in IDLE; gnt is high from cycle N+1. The first access happens in cycle N+1.
- Write-to-read switch costs 2 cycles without access: the release edge plus TURN. Read-to-read costs 1.
- ram_addr, ram_we and ram_oe are combinational from registered grants and requester inputs, with no added latency. Requesters must present a stable address in their access cycle.
- A req toggling while not granted has no effect until the next arbitration point.
- Preempted owners must keep req high if they still need access; they are re-granted per priority.

## Structure
- Shared package (training-engine constants): state encoding, the requester index constants LOAD=0/SGD=1/DUMP=2, and the default ADDR_WIDTH.
- No sub-module is needed. The FSM, burst counter and round-robin pointer are one always block plus output decode (about 150–250 lines).

## Test plan
- Reset and idle: RST=0 for 3 cycles, then 1, with all reqs low → all outputs 0, busy 0.
- Single load burst: req_load high for 5 cycles with addr 0..4 → gnt_load high cycles 1–5, ram_we high 5 cycles, ram_addr sequences 0..4, gnt drops the cycle after req falls.
- Priority and turnaround: req_sgd and req_load rise together → load granted first; when load releases, one TURN cycle follows, then gnt_sgd.
- Round-robin with burst limit (MAX_BURST=4): req_sgd and req_dump held high → grants alternate SGD 4 accesses, dump 4, SGD 4, with no TURN between them.
- Burst saturation: only req_sgd held for 20 cycles with MAX_BURST=4 → gnt_sgd stays continuously high and ram_oe is high 20 cycles.
- Async reset mid-burst: RST low while gnt_dump is high, between clock edges → gnt_dump, ram_oe and busy go low immediately. After release, arbitration restarts from IDLE with SGD winning the tie.
